// File: rtl/rat_intr_pkg.sv
// Shared constants, FSM state type and priority helper for the RAT interrupt controller.
package rat_intr_pkg;

  localparam int unsigned REG_W = 8;
  localparam int unsigned CNT_W = 4;

  localparam logic [7:0] OFF_MASK   = 8'd0;
  localparam logic [7:0] OFF_MODE   = 8'd1;
  localparam logic [7:0] OFF_POL    = 8'd2;
  localparam logic [7:0] OFF_PEND   = 8'd3;
  localparam logic [7:0] OFF_VECTOR = 8'd4;
  localparam logic [7:0] OFF_CTRL   = 8'd5;
  localparam logic [7:0] WIN_SIZE   = 8'd6;

  localparam int unsigned CTRL_GEN_BIT = 0;
  localparam int unsigned CTRL_ACK_BIT = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  // Index of the lowest set bit; bit 0 has the highest priority.
  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rat_sync.sv
// Single-bit synchroniser: STAGES flops, asynchronously cleared.
module rat_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/rat_intr_ctrl.sv
// Port-mapped interrupt controller: per-source sync, edge/level pending logic,
// masked priority vector and an IDLE/ACTIVE/HOLDOFF INTR handshake.
module rat_intr_ctrl
  import rat_intr_pkg::*;
#(
  parameter int unsigned N_SRC       = 8,
  parameter logic [7:0]  BASE_ID     = 8'hF0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLDOFF_CYC = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] IRQ_IN,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  output logic [7:0]       RD_DATA,
  output logic             RD_HIT,
  output logic             INTR
);

  logic [N_SRC-1:0] wdata, sync_q, act, prev, prev_n, rise;
  logic [N_SRC-1:0] mask, mode, pol, pend, pend_n, act_msk;
  logic [SYNC_STAGES:0] prime;
  logic             gen, any, intr_q;
  logic [2:0]       vec_idx;
  logic [7:0]       off, vector, rd_mux;
  logic             hit, wr, wr_mask, wr_mode, wr_pol, wr_pend, wr_ctrl;
  logic             ack_req, ack;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    rat_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (CLK),
      .rst (RESET),
      .d   (IRQ_IN[g]),
      .q   (sync_q[g])
    );
  end

  // Address decode and write strobes
  assign wdata   = OUT_PORT[N_SRC-1:0];
  assign off     = PORT_ID - BASE_ID;
  assign hit     = (off < WIN_SIZE);
  assign wr      = IO_STRB && hit;
  assign wr_mask = wr && (off == OFF_MASK);
  assign wr_mode = wr && (off == OFF_MODE);
  assign wr_pol  = wr && (off == OFF_POL);
  assign wr_pend = wr && (off == OFF_PEND);
  assign wr_ctrl = wr && (off == OFF_CTRL);
  assign ack_req = wr_ctrl && OUT_PORT[CTRL_ACK_BIT];
  assign ack     = ack_req && (state == ST_ACTIVE);

  assign act     = sync_q ^ pol;
  assign act_msk = pend & mask;
  assign any     = |act_msk;
  assign vec_idx = lowest_idx(8'(act_msk));
  assign vector  = {any, 4'b0000, vec_idx};

  // Edges count only once prev holds a real post-reset sample, so a source
  // held active through reset needs a fresh edge.
  assign rise   = act & ~prev & {N_SRC{prime[SYNC_STAGES]}};
  assign prev_n = wr_pol ? (sync_q ^ wdata) : act;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mask <= '0;
      mode <= '0;
      pol  <= '0;
      gen  <= 1'b0;
    end else begin
      if (wr_mask) mask <= wdata;
      if (wr_mode) mode <= wdata;
      if (wr_pol)  pol  <= wdata;
      if (wr_ctrl && !OUT_PORT[CTRL_ACK_BIT]) gen <= OUT_PORT[CTRL_GEN_BIT];
    end
  end

  // Pending: edge set beats W1C/ACK clear; level tracks act; mode change clears.
  always_comb begin
    pend_n = pend;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (mode[i]) begin
        if ((wr_pend && wdata[i]) || (ack && (3'(i) == vec_idx))) pend_n[i] = 1'b0;
        if (rise[i]) pend_n[i] = 1'b1;
      end else begin
        pend_n[i] = act[i];
      end
    end
    if (wr_mode) pend_n = pend_n & ~(mode ^ wdata);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      prev  <= '0;
      pend  <= '0;
      prime <= '0;
    end else begin
      prev  <= prev_n;
      pend  <= pend_n;
      prime <= {prime[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      intr_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      intr_q <= (state_n == ST_ACTIVE);
    end
  end

  // Holdoff exits as the counter reaches zero, straight to ACTIVE if work is
  // waiting, so INTR stays low for exactly HOLDOFF_CYC cycles.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (gen && any) state_n = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (ack) begin
          state_n = ST_HOLDOFF;
          cnt_n   = CNT_W'(HOLDOFF_CYC);
        end else if (!(gen && any)) begin
          state_n = ST_IDLE;
        end
      end
      ST_HOLDOFF: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          cnt_n   = '0;
          state_n = (gen && any) ? ST_ACTIVE : ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_MASK:   rd_mux = REG_W'(mask);
      OFF_MODE:   rd_mux = REG_W'(mode);
      OFF_POL:    rd_mux = REG_W'(pol);
      OFF_PEND:   rd_mux = REG_W'(pend);
      OFF_VECTOR: rd_mux = vector;
      OFF_CTRL:   rd_mux = {7'd0, gen};
      default:    rd_mux = '0;
    endcase
  end

  assign RD_DATA = hit ? rd_mux : 8'h00;
  assign RD_HIT  = hit;
  assign INTR    = intr_q;

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Bench for rat_intr_ctrl: directed scenarios plus random traffic against a
// rule-level reference model; an N_SRC=3 instance covers unimplemented bits.
module tb_rat_intr_ctrl;

  localparam int         S    = 2;
  localparam int         HOLD = 4;
  localparam logic [7:0] BASE = 8'hF0;

  logic       CLK, RESET, IO_STRB, RD_HIT, INTR, rd_hit3, intr3;
  logic [7:0] IRQ_IN, PORT_ID, OUT_PORT, RD_DATA, rd_data3;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] irq_cur;
  logic [7:0] m_pipe [S];
  logic [7:0] m_prev, m_pend, m_mask, m_mode, m_pol;
  logic       m_gen, m_intr;
  int         m_hold, m_age;

  rat_intr_ctrl dut (
    .CLK(CLK), .RESET(RESET), .IRQ_IN(IRQ_IN), .PORT_ID(PORT_ID),
    .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB), .RD_DATA(RD_DATA),
    .RD_HIT(RD_HIT), .INTR(INTR)
  );

  rat_intr_ctrl #(.N_SRC(3)) dut3 (
    .CLK(CLK), .RESET(RESET), .IRQ_IN(IRQ_IN[2:0]), .PORT_ID(PORT_ID),
    .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB), .RD_DATA(rd_data3),
    .RD_HIT(rd_hit3), .INTR(intr3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < S; s++) m_pipe[s] = 8'h00;
    m_prev = 0; m_pend = 0; m_mask = 0; m_mode = 0; m_pol = 0;
    m_gen = 0; m_intr = 0; m_hold = 0; m_age = 0;
  endtask

  function automatic logic m_hit(input logic [7:0] port);
    logic [7:0] o;
    o = port - BASE;
    return o < 8'd6;
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] port);
    logic [7:0] o, actm;
    int lo;
    o = port - BASE;
    actm = m_pend & m_mask;
    lo = 0;
    for (int i = 7; i >= 0; i--) if (actm[i]) lo = i;
    case (o)
      8'd0: return m_mask;
      8'd1: return m_mode;
      8'd2: return m_pol;
      8'd3: return m_pend;
      8'd4: return (actm != 0) ? (8'h80 | 8'(lo)) : 8'h00;
      8'd5: return {7'd0, m_gen};
      default: return 8'h00;
    endcase
  endfunction

  // One clock of the controller's rules, from pre-edge state and stable inputs.
  task automatic model_step();
    logic [7:0] sync, act, actm, np, o, d;
    logic wr, ack;
    int lo;
    sync = m_pipe[S-1];
    act  = sync ^ m_pol;
    actm = m_pend & m_mask;
    lo = 0;
    for (int i = 7; i >= 0; i--) if (actm[i]) lo = i;
    o   = PORT_ID - BASE;
    d   = OUT_PORT;
    wr  = IO_STRB && (o < 8'd6);
    ack = wr && (o == 8'd5) && d[7] && m_intr;
    for (int i = 0; i < 8; i++) begin
      if (m_mode[i])
        np[i] = (act[i] && !m_prev[i] && m_age > S) ||
                (m_pend[i] && !(wr && o == 8'd3 && d[i]) && !(ack && i == lo));
      else
        np[i] = act[i];
    end
    if (wr && o == 8'd1) np = np & ~(m_mode ^ d);
    if (ack) begin
      m_intr = 1'b0;
      m_hold = HOLD - 1;
    end else if (m_hold > 0) begin
      m_intr = 1'b0;
      m_hold--;
    end else begin
      m_intr = m_gen && (actm != 0);
    end
    m_prev = (wr && o == 8'd2) ? (sync ^ d) : act;
    for (int s = S - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
    m_pipe[0] = IRQ_IN;
    if (wr && o == 8'd0) m_mask = d;
    if (wr && o == 8'd1) m_mode = d;
    if (wr && o == 8'd2) m_pol = d;
    if (wr && o == 8'd5 && !d[7]) m_gen = d[0];
    m_pend = np;
    if (m_age < 1000) m_age++;
  endtask

  task automatic cycle(input logic [7:0] port, input logic [7:0] data, input logic strb);
    @(negedge CLK);
    IRQ_IN = irq_cur; PORT_ID = port; OUT_PORT = data; IO_STRB = strb;
    #1;
    check("rd_hit", 8'(RD_HIT), 8'(m_hit(port)));
    check("rd_data", RD_DATA, m_read(port));
    @(posedge CLK);
    model_step();
    #1;
    check("intr", 8'(INTR), 8'(m_intr));
  endtask

  task automatic wr(input logic [7:0] o, input logic [7:0] data);
    cycle(BASE + o, data, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(8'h00, 8'h00, 1'b0);
  endtask

  task automatic pulse(input logic [7:0] bits);
    irq_cur = bits;
    idle(1);
    irq_cur = 8'h00;
  endtask

  task automatic peek(input logic [7:0] o, input logic [7:0] exp, input string tag);
    PORT_ID = BASE + o; IO_STRB = 1'b0;
    #1;
    check(tag, RD_DATA, exp);
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (!INTR && n < 20) begin
      n++;
      idle(1);
    end
  endtask

  int n;
  logic [7:0] port, data;
  int op;

  initial begin
    RESET = 1'b1; IRQ_IN = 0; PORT_ID = 0; OUT_PORT = 0; IO_STRB = 0; irq_cur = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_intr", 8'(INTR), 8'h00);
    check("rst_intr3", 8'(intr3), 8'h00);
    for (int o = 0; o < 6; o++) peek(8'(o), 8'h00, "rst_reg");
    @(negedge CLK);
    RESET = 1'b0;

    // Single edge on ch2 through sync, pend and INTR
    wr(5, 8'h01); wr(0, 8'h04); wr(1, 8'h04);
    pulse(8'h04);
    idle(2);
    peek(3, 8'h04, "pend_ch2");
    check("intr_before", 8'(INTR), 8'h00);
    idle(1);
    check("intr_ch2", 8'(INTR), 8'h01);
    peek(4, 8'h82, "vec_ch2");
    wr(3, 8'h04);

    // Priority, ACK clear and holdoff length
    wr(0, 8'hFF); wr(1, 8'hFF);
    pulse(8'h22);
    idle(3);
    peek(4, 8'h81, "vec_ch1");
    wr(5, 8'h81);
    peek(3, 8'h20, "pend_after_ack");
    count_low(n);
    check("holdoff_len", 8'(n), 8'd4);
    check("intr_after_hold", 8'(INTR), 8'h01);
    peek(4, 8'h85, "vec_ch5");
    wr(3, 8'hFF);

    // Level channel 0
    wr(1, 8'hFE);
    irq_cur = 8'h01;
    idle(4);
    check("lvl_intr", 8'(INTR), 8'h01);
    wr(5, 8'h81);
    peek(3, 8'h01, "lvl_pend_ack");
    count_low(n);
    check("lvl_holdoff", 8'(n), 8'd4);
    irq_cur = 8'h00;
    n = 0;
    do begin
      idle(1);
      n++;
    end while (INTR && n < 10);
    check("lvl_drop", 8'(n <= S + 2), 8'h01);

    // Edge set beats same-cycle W1C; POL write makes no edge
    pulse(8'h08);
    idle(1);
    wr(3, 8'h08);
    peek(3, 8'h08, "set_wins");
    wr(3, 8'h08);
    wr(2, 8'h08);
    idle(4);
    peek(3, 8'h00, "pol_no_edge");
    wr(2, 8'h00);

    // Reset mid-holdoff
    pulse(8'h10);
    idle(3);
    check("pre_hold_intr", 8'(INTR), 8'h01);
    wr(5, 8'h81);
    idle(1);
    #1 RESET = 1'b1;
    model_reset();
    #1 check("async_rst_intr", 8'(INTR), 8'h00);
    peek(0, 8'h00, "async_rst_mask");
    peek(1, 8'h00, "async_rst_mode");
    peek(3, 8'h00, "async_rst_pend");
    peek(5, 8'h00, "async_rst_ctrl");
    irq_cur = 8'h40; IRQ_IN = 8'h40;
    @(negedge CLK);
    RESET = 1'b0;
    wr(1, 8'hFF);
    idle(4);
    peek(3, 8'h00, "held_thru_reset");
    irq_cur = 8'h00;
    idle(3);
    pulse(8'h02);
    idle(2);
    wr(5, 8'h80);
    peek(3, 8'h02, "ack_idle_pend");
    peek(5, 8'h00, "ack_idle_ctrl");
    check("ack_idle_intr", 8'(INTR), 8'h00);

    // Unimplemented bits on the 3-source build, out-of-window read
    wr(0, 8'hFF);
    PORT_ID = BASE; IO_STRB = 1'b0;
    #1 check("n3_mask", rd_data3, 8'h07);
    PORT_ID = BASE + 8'd6;
    #1;
    check("n3_hit", 8'(rd_hit3), 8'h00);
    check("n3_data", rd_data3, 8'h00);
    check("oow_hit", 8'(RD_HIT), 8'h00);
    check("oow_data", RD_DATA, 8'h00);

    // Random traffic against the model
    wr(5, 8'h01);
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) irq_cur = irq_cur ^ (8'h01 << $urandom_range(0, 7));
      op = $urandom_range(0, 19);
      if ($urandom_range(0, 7) == 0) port = 8'($urandom);
      else port = BASE + 8'($urandom_range(0, 6));
      data = 8'($urandom);
      if (op < 14)       cycle(port, data, 1'b0);
      else if (op < 16)  wr(5, {1'b1, 6'd0, m_gen});
      else if (op == 16) wr(3, data);
      else if (op == 17) wr(0, data);
      else if (op == 18) wr(8'($urandom_range(1, 2)), data);
      else               wr(5, {7'd0, ($urandom_range(0, 3) != 0)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
